fft_2_8_dif: RTL and testbench

- Streaming 8-point radix-2 decimation-in-frequency FFT on real, signed 16-bit samples.
- Collects 8 consecutive qualified samples into one frame and computes the full 8-point DFT (three butterfly stages, with the input-side twiddles applied in stage 1).
- Emits the 8 complex bins serially in natural order, one bin per clock, packed with a valid flag into one 37-bit word.
- Sits between a sample source (ADC/front-end) and spectral post-processing.

---
 rtl/fft_2_8_dif.sv | 125 ++++++++++++
 tb/tb_fft_2_8_dif.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_2_8_dif.sv
// Streaming 8-point radix-2 DIF FFT on real 16-bit samples.
// Collects a frame into an input buffer, computes all bins in one cycle, then streams X0..X7.
module fft_2_8_dif (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [15:0] data_in,
  output logic [36:0] data_out
);

  logic signed [15:0] x_q [8];
  logic signed [15:0] x_d [8];
  logic [2:0]         n_q, n_d;
  logic               frame_done_q, frame_done_d;
  logic [35:0]        obuf_q [8];
  logic [35:0]        obuf_d [8];
  logic [3:0]         rem_q, rem_d;

  logic signed [19:0] xe [8];
  logic signed [19:0] a [4];
  logic signed [19:0] d [4];
  logic signed [19:0] r1, r3;
  logic signed [19:0] br [4];
  logic signed [19:0] bi [4];
  logic signed [19:0] ea0, ea1, fa0, fa1i;
  logic signed [19:0] e0r, e0i, e1r, e1i, f0r, f0i, f1r, f1i;
  logic signed [19:0] xr [8];
  logic signed [19:0] xi [8];
  logic signed [19:0] sr [8];
  logic signed [19:0] si [8];
  logic [35:0]        bin [8];

  // Multiply by 0.70711 in Q14 with round-half-up.
  function automatic logic signed [19:0] rnd(input logic signed [19:0] v);
    logic signed [35:0] p;
    p = v * 36'sd11585 + 36'sd8192;
    return 20'(p >>> 14);
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) xe[k] = {{4{x_q[k][15]}}, x_q[k]};
    for (int k = 0; k < 4; k++) begin
      a[k] = xe[k] + xe[k+4];
      d[k] = xe[k] - xe[k+4];
    end
    r1 = rnd(d[1]);
    r3 = rnd(d[3]);
    br[0] = d[0]; bi[0] = 20'sd0;
    br[1] = r1;   bi[1] = -r1;
    br[2] = 20'sd0; bi[2] = -d[2];
    br[3] = -r3;  bi[3] = -r3;

    // Even bins: purely real group, the -j rotation only moves a3-a1 into the imaginary part.
    ea0  = a[0] + a[2];
    ea1  = a[1] + a[3];
    fa0  = a[0] - a[2];
    fa1i = a[3] - a[1];
    xr[0] = ea0 + ea1; xi[0] = 20'sd0;
    xr[4] = ea0 - ea1; xi[4] = 20'sd0;
    xr[2] = fa0;       xi[2] = fa1i;
    xr[6] = fa0;       xi[6] = -fa1i;

    // Odd bins: complex group; (p1-p3)*(-j) = (im, -re).
    e0r = br[0] + br[2]; e0i = bi[0] + bi[2];
    e1r = br[1] + br[3]; e1i = bi[1] + bi[3];
    f0r = br[0] - br[2]; f0i = bi[0] - bi[2];
    f1r = bi[1] - bi[3]; f1i = br[3] - br[1];
    xr[1] = e0r + e1r; xi[1] = e0i + e1i;
    xr[5] = e0r - e1r; xi[5] = e0i - e1i;
    xr[3] = f0r + f1r; xi[3] = f0i + f1i;
    xr[7] = f0r - f1r; xi[7] = f0i - f1i;

    for (int k = 0; k < 8; k++) begin
      sr[k]  = xr[k] >>> 1;
      si[k]  = xi[k] >>> 1;
      bin[k] = {sr[k][17:0], si[k][17:0]};
    end
  end

  always_comb begin
    x_d          = x_q;
    n_d          = n_q;
    frame_done_d = 1'b0;
    if (valid) begin
      x_d[n_q]     = data_in;
      n_d          = n_q + 3'd1;
      frame_done_d = (n_q == 3'd7);
    end
  end

  // A fresh frame always lands after the previous run has drained, so load wins outright.
  always_comb begin
    obuf_d = obuf_q;
    rem_d  = rem_q;
    if (frame_done_q) begin
      obuf_d = bin;
      rem_d  = 4'd8;
    end else if (rem_q != 4'd0) begin
      for (int k = 0; k < 7; k++) obuf_d[k] = obuf_q[k+1];
      obuf_d[7] = '0;
      rem_d     = rem_q - 4'd1;
    end
  end

  assign data_out = (rem_q != 4'd0) ? {1'b1, obuf_q[0]} : 37'd0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        x_q[k]    <= '0;
        obuf_q[k] <= '0;
      end
      n_q          <= '0;
      frame_done_q <= 1'b0;
      rem_q        <= '0;
    end else begin
      x_q          <= x_d;
      n_q          <= n_d;
      frame_done_q <= frame_done_d;
      obuf_q       <= obuf_d;
      rem_q        <= rem_d;
    end
  end

endmodule

// File: tb/tb_fft_2_8_dif.sv
// Directed self-checking bench for fft_2_8_dif: hand-computed bins per scenario.
module tb_fft_2_8_dif;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [15:0] data_in;
  logic [36:0] data_out;

  int checks;
  int errors;
  int samp [8];
  int samp2 [8];
  int er [8];
  int ei [8];
  int er2 [8];
  int ei2 [8];

  fft_2_8_dif dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] pk(input int re, input int im);
    logic [17:0] r;
    logic [17:0] i;
    r = re[17:0];
    i = im[17:0];
    return {1'b1, r, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    valid = 1'b0;
    tick();
    rst_n = 1'b0;
  endtask

  // Drive samp[] as one frame; leaves time at #1 after the x7 capture edge.
  task automatic drive_frame(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        valid = 1'b0;
        data_in = 16'hdead;
        tick();
      end
      valid   = 1'b1;
      data_in = samp[i][15:0];
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic set_basic();
    samp = '{12, 49, 2, 48, 70, 13, 5, 6};
    er   = '{102, -32, 37, -27, -14, -27, 37, -32};
    ei   = '{0, -26, -4, -29, 0, 29, 4, 26};
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid = 1'b0; data_in = '0;
    tick(); tick();
    rst_n = 1'b0;
    checks++;
    if (data_out !== 37'd0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", data_out);
    end
    tick(); tick();
    checks++;
    if (data_out !== 37'd0) begin
      errors++;
      $display("FAIL idle_out: got %h want 0", data_out);
    end
  endtask

  task automatic test_vector(input string name, input bit gaps);
    drive_frame(gaps);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (data_out !== pk(er[k], ei[k])) begin
        errors++;
        $display("FAIL %s bin%0d: got %h want %h", name, k, data_out, pk(er[k], ei[k]));
      end
    end
    tick();
    checks++;
    if (data_out !== 37'd0) begin
      errors++;
      $display("FAIL %s tail: got %h want 0", name, data_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_basic();
    test_vector("basic", 1'b0);
  endtask

  task automatic test_impulse_constant();
    samp = '{100, 0, 0, 0, 0, 0, 0, 0};
    er   = '{50, 50, 50, 50, 50, 50, 50, 50};
    ei   = '{0, 0, 0, 0, 0, 0, 0, 0};
    test_vector("impulse", 1'b0);
    samp = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    er   = '{4000, 0, 0, 0, 0, 0, 0, 0};
    test_vector("constant", 1'b0);
  endtask

  task automatic test_extremes();
    samp = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    er   = '{-131072, 0, 0, 0, 0, 0, 0, 0};
    ei   = '{0, 0, 0, 0, 0, 0, 0, 0};
    test_vector("neg_full", 1'b0);
    // Sum of the alternating frame is -4, so X0 floors to -2.
    samp = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
    er   = '{-2, 0, 0, 0, 131070, 0, 0, 0};
    test_vector("alternating", 1'b0);
  endtask

  task automatic test_valid_gaps();
    set_basic();
    test_vector("gaps", 1'b1);
  endtask

  task automatic test_back_to_back();
    set_basic();
    samp2 = '{100, 0, 0, 0, 0, 0, 0, 0};
    er2   = '{50, 50, 50, 50, 50, 50, 50, 50};
    ei2   = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      valid   = 1'b1;
      data_in = (i < 8) ? samp[i][15:0] : samp2[i-8][15:0];
      tick();
      if (i >= 8) begin
        checks++;
        if (data_out !== pk(er[i-8], ei[i-8])) begin
          errors++;
          $display("FAIL b2b_f1 bin%0d: got %h want %h", i - 8, data_out, pk(er[i-8], ei[i-8]));
        end
      end
    end
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (data_out !== pk(er2[k], ei2[k])) begin
        errors++;
        $display("FAIL b2b_f2 bin%0d: got %h want %h", k, data_out, pk(er2[k], ei2[k]));
      end
    end
    tick();
    checks++;
    if (data_out !== 37'd0) begin
      errors++;
      $display("FAIL b2b tail: got %h want 0", data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 5; i++) begin
      valid   = 1'b1;
      data_in = 16'(1000 + i * 77);
      tick();
    end
    do_reset();
    set_basic();
    test_vector("rst_mid_frame", 1'b0);
  endtask

  task automatic test_reset_mid_output();
    set_basic();
    drive_frame(1'b0);
    tick();
    tick();
    checks++;
    if (data_out !== pk(er[1], ei[1])) begin
      errors++;
      $display("FAIL rst_mid_out pre: got %h want %h", data_out, pk(er[1], ei[1]));
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (data_out !== 37'd0) begin
      errors++;
      $display("FAIL rst_mid_out edge: got %h want 0", data_out);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (data_out !== 37'd0) begin
        errors++;
        $display("FAIL rst_mid_out after%0d: got %h want 0", k, data_out);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    valid = 1'b0;
    data_in = '0;
    test_reset();
    test_basic();
    test_impulse_constant();
    test_extremes();
    test_valid_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_mid_output();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
